// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and kill.
// Define SRV_MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle multiplier.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      opc,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      opc_q, opc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            byp_q, byp_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic            accept_c;
  logic            s1_sgn_c, s2_sgn_c, neg1_c, neg2_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic            div_zero_c, ovf_c, special_c, bypass_c;
  logic [XLEN-1:0] spec_res_c, byp_res_c;

  logic [XLEN:0]   add_c;
  logic [AW-1:0]   mul_next_c;
  logic [XLEN:0]   rem_sh_c;
  logic [XLEN+1:0] sub_c;
  logic            qbit_c;
  logic [XLEN-1:0] new_rem_c;
  logic [AW-1:0]   div_next_c;

  logic [AW-1:0]   prod_c;
  logic [XLEN-1:0] quo_c, rem_c, fix_res_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;

  assign accept_c = in_valid & in_ready_q & ~kill;

  // Operand signedness, magnitudes and the divide corner cases.
  always_comb begin : operand_prep
    s1_sgn_c   = (opc == OP_MULH) || (opc == OP_MULHSU) || (opc == OP_DIV) || (opc == OP_REM);
    s2_sgn_c   = (opc == OP_MULH) || (opc == OP_DIV) || (opc == OP_REM);
    neg1_c     = s1_sgn_c & s1[XLEN-1];
    neg2_c     = s2_sgn_c & s2[XLEN-1];
    a_mag_c    = neg1_c ? -s1 : s1;
    b_mag_c    = neg2_c ? -s2 : s2;
    div_zero_c = (s2 == '0);
    ovf_c      = (s1 == {1'b1, {(XLEN-1){1'b0}}}) && (s2 == '1) && !opc[0];
    special_c  = opc[2] & (div_zero_c | ovf_c);
    if (div_zero_c) begin
      spec_res_c = opc[1] ? s1 : '1;
    end else begin
      spec_res_c = opc[1] ? '0 : s1;
    end
  end

`ifdef SRV_MULDIV_FAST_MUL_EN
  logic signed [AW-1:0] fa_c, fb_c, fp_c;
  logic [XLEN-1:0]      fast_res_c;

  // Low 2*XLEN bits of the signed (XLEN+1)x(XLEN+1) product of extended operands.
  always_comb begin : fast_mul
    fa_c       = {{XLEN{neg1_c}}, s1};
    fb_c       = {{XLEN{neg2_c}}, s2};
    fp_c       = fa_c * fb_c;
    fast_res_c = (opc == OP_MUL) ? fp_c[XLEN-1:0] : fp_c[AW-1:XLEN];
  end

  always_comb begin : bypass_sel
    bypass_c  = special_c | ~opc[2];
    byp_res_c = special_c ? spec_res_c : fast_res_c;
  end
`else
  always_comb begin : bypass_sel
    bypass_c  = special_c;
    byp_res_c = spec_res_c;
  end
`endif

  // One radix-2 iteration: shift-add multiply or restoring divide on acc_q = {hi, lo}.
  always_comb begin : step
    add_c      = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next_c = {add_c, acc_q[XLEN-1:1]};
    rem_sh_c   = acc_q[AW-1:XLEN-1];
    sub_c      = {1'b0, rem_sh_c} + {1'b0, ~{1'b0, b_q}} + (XLEN+2)'(1);
    qbit_c     = sub_c[XLEN+1];
    new_rem_c  = qbit_c ? XLEN'(sub_c[XLEN:0]) : XLEN'(rem_sh_c);
    div_next_c = {new_rem_c, acc_q[XLEN-2:0], qbit_c};
  end

  // Sign fix-up and result selection.
  always_comb begin : fixup
    prod_c = neg_q ? -acc_q : acc_q;
    quo_c  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_c  = rneg_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    if (opc_q[2]) begin
      fix_res_c = opc_q[1] ? rem_c : quo_c;
    end else begin
      fix_res_c = (opc_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[AW-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; bypassed results pass through FIX so all paths register out_valid alike.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = bypass_c ? FIX : CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
    end
  end

  // Datapath and registered-output next values.
  always_comb begin : outputs
    opc_d  = opc_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    byp_d  = byp_q;
    res_d  = res_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          opc_d  = opc;
          b_d    = b_mag_c;
          acc_d  = {{XLEN{1'b0}}, bypass_c ? byp_res_c : a_mag_c};
          cnt_d  = CW'(XLEN - 1);
          neg_d  = neg1_c ^ neg2_c;
          rneg_d = neg1_c;
          byp_d  = bypass_c;
        end
      end
      CALC: begin
        acc_d = opc_q[2] ? div_next_c : mul_next_c;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (!kill) begin
          res_d = byp_q ? acc_q[XLEN-1:0] : fix_res_c;
        end
      end
      default: ;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q       <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      byp_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      opc_q       <= opc_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      byp_q       <= byp_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule
